// File: rtl/ram_arbiter_if.sv
// Shared backing-RAM bus between the two caches and ram_arbiter.
// master = cache side, slave = arbiter side.
interface ram_arbiter_if;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_grant;
    logic        i_read;
    logic [31:0] i_addr;
    logic        i_grant;
    logic        ram_ready;
    logic [31:0] rdata;

    modport master (
        output d_read, d_write, d_addr, d_wdata,
        output i_read, i_addr,
        input  d_grant, i_grant, ram_ready, rdata
    );

    modport slave (
        input  d_read, d_write, d_addr, d_wdata,
        input  i_read, i_addr,
        output d_grant, i_grant, ram_ready, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a multi-cycle byte-addressed RAM.
// Data port: write-back plus fill; instruction port: read only.
module ram_arbiter #(
    parameter int    MemBytes = 4096,
    parameter int    Latency  = 4,
    parameter string InitFile = ""
) (
    input  logic        clock,
    input  logic        reset,
    ram_arbiter_if.slave bus,
    output logic [31:0] rd_count_d,
    output logic [31:0] rd_count_i,
    output logic [31:0] wr_count
);
    localparam int AW = $clog2(MemBytes);
    localparam int CW = (Latency > 1) ? $clog2(Latency) : 1;
    localparam logic [CW-1:0] LatM1 = CW'(Latency - 1);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT, READY} state_t;

    state_t        state, state_nx;
    logic          owner, owner_nx;
    logic          last_owner;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   rdata_q;
    logic          dreq, take_d;
    logic [AW-1:0] wa, ra;
    logic          unused_hi;

    logic [7:0] mem [MemBytes];

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
    end

    // owner: 1 = data port, 0 = instruction port
    assign dreq   = bus.d_read | bus.d_write;
    assign take_d = dreq && (!bus.i_read || !last_owner);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && state_nx != IDLE)
                last_owner <= owner_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (dreq || bus.i_read) begin
                    owner_nx = take_d;
                    cnt_nx   = LatM1;
                    state_nx = (take_d && bus.d_write) ? WRITE : WAIT;
                end
            end
            WRITE: begin
                cnt_nx   = LatM1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nx = READY;
                else cnt_nx = cnt - CW'(1);
            end
            READY: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.d_grant   = (state != IDLE) && owner;
        bus.i_grant   = (state != IDLE) && !owner;
        bus.ram_ready = (state == READY);
        bus.rdata     = rdata_q;
    end

    assign wa = bus.d_addr[AW-1:0];
    assign ra = owner ? bus.d_addr[AW-1:0] : bus.i_addr[AW-1:0];
    assign unused_hi = ^{bus.d_addr[31:AW], bus.i_addr[31:AW]};

    // RAM has no reset; state is already IDLE under reset so no write lands
    always @(posedge clock) begin
        if (state == WRITE) begin
            mem[wa]          <= bus.d_wdata[31:24];
            mem[wa + AW'(1)] <= bus.d_wdata[23:16];
            mem[wa + AW'(2)] <= bus.d_wdata[15:8];
            mem[wa + AW'(3)] <= bus.d_wdata[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q    <= '0;
            rd_count_d <= '0;
            rd_count_i <= '0;
            wr_count   <= '0;
        end else begin
            if (state == WAIT && cnt == '0)
                rdata_q <= {mem[ra], mem[ra + AW'(1)],
                            mem[ra + AW'(2)], mem[ra + AW'(3)]};
            if (state == WRITE)
                wr_count <= wr_count + 32'd1;
            if (state == READY) begin
                if (owner) rd_count_d <= rd_count_d + 32'd1;
                else       rd_count_i <= rd_count_i + 32'd1;
            end
        end
    end
endmodule
